// File: rtl/sm83_pkg.sv
// Shared SM83 core types: stack sequencer pair selects, states and flag masking.
package sm83_pkg;

  typedef enum logic [2:0] {
    SEL_BC = 3'd0,
    SEL_DE = 3'd1,
    SEL_HL = 3'd2,
    SEL_AF = 3'd3,
    SEL_PC = 3'd4
  } stack_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_HI = 3'd1,
    ST_PUSH_LO = 3'd2,
    ST_POP_LO  = 3'd3,
    ST_POP_HI  = 3'd4,
    ST_DONE    = 3'd5
  } stack_state_t;

  // Lower nibble of F is hard-wired to zero on the SM83.
  localparam logic [7:0] F_LOW_MASK = 8'hF0;

  function automatic logic sel_is_valid(input logic [2:0] sel);
    return sel <= 3'(SEL_PC);
  endfunction

endpackage

// File: rtl/sm83_stack_seq.sv
// SM83 stack sequencer: owns SP and performs PUSH/POP of a register pair as
// two byte-wide memory cycles, driving the register file write strobes.
module sm83_stack_seq
  import sm83_pkg::*;
#(
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_push,
  input  logic [2:0]  req_sel,
  input  logic        sp_load,
  input  logic [15:0] sp_load_val,
  output logic [15:0] sp,
  output logic [2:0]  rf_sel,
  input  logic [7:0]  rd_hi,
  input  logic [7:0]  rd_lo,
  output logic        rf_wen_hi,
  output logic        rf_wen_lo,
  output logic [7:0]  rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        done
);

  stack_state_t r_state;
  logic [15:0]  r_sp;
  logic [2:0]   r_sel;
  logic [15:0]  w_sp_dec;
  logic [15:0]  w_sp_inc;

  assign w_sp_dec = r_sp - 16'd1;
  assign w_sp_inc = r_sp + 16'd1;

  // The push/pop direction is carried by the state itself after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sp    <= SP_RESET;
      r_sel   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (sp_load) begin
            r_sp <= sp_load_val;
          end else if (req_valid) begin
            r_sel <= req_sel;
            if (!sel_is_valid(req_sel)) r_state <= ST_DONE;
            else if (req_push)          r_state <= ST_PUSH_HI;
            else                        r_state <= ST_POP_LO;
          end
        end
        ST_PUSH_HI: if (mem_ack) begin
          r_sp    <= w_sp_dec;
          r_state <= ST_PUSH_LO;
        end
        ST_PUSH_LO: if (mem_ack) begin
          r_sp    <= w_sp_dec;
          r_state <= ST_DONE;
        end
        ST_POP_LO: if (mem_ack) begin
          r_sp    <= w_sp_inc;
          r_state <= ST_POP_HI;
        end
        ST_POP_HI: if (mem_ack) begin
          r_sp    <= w_sp_inc;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sp = r_sp;

  always_comb begin
    req_ready = 1'b0;
    rf_sel    = r_sel;
    rf_wen_hi = 1'b0;
    rf_wen_lo = 1'b0;
    rf_wdata  = 8'h00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = !sp_load;
        rf_sel    = 3'd0;
      end
      ST_PUSH_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_sp_dec;
        mem_wdata = rd_hi;
      end
      ST_PUSH_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_sp_dec;
        mem_wdata = rd_lo;
      end
      ST_POP_LO: begin
        mem_req  = 1'b1;
        mem_addr = r_sp;
        if (mem_ack) begin
          rf_wen_lo = 1'b1;
          rf_wdata  = (r_sel == 3'(SEL_AF)) ? (mem_rdata & F_LOW_MASK) : mem_rdata;
        end
      end
      ST_POP_HI: begin
        mem_req  = 1'b1;
        mem_addr = r_sp;
        if (mem_ack) begin
          rf_wen_hi = 1'b1;
          rf_wdata  = mem_rdata;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm83_stack_seq.sv
// Directed bench for sm83_stack_seq: push/pop timing, waits, wrap, sp_load and reset abort.
module tb_sm83_stack_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_push;
  logic [2:0]  req_sel;
  logic        sp_load;
  logic [15:0] sp_load_val;
  logic [15:0] sp;
  logic [2:0]  rf_sel;
  logic [7:0]  rd_hi;
  logic [7:0]  rd_lo;
  logic        rf_wen_hi;
  logic        rf_wen_lo;
  logic [7:0]  rf_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] rf_hi [0:4];
  logic [7:0] rf_lo [0:4];

  always #5 clk = ~clk;

  always_comb begin
    rd_hi = 8'h00;
    rd_lo = 8'h00;
    if (rf_sel <= 3'd4) begin
      rd_hi = rf_hi[rf_sel];
      rd_lo = rf_lo[rf_sel];
    end
  end

  sm83_stack_seq #(.SP_RESET(16'hFFFE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_push(req_push), .req_sel(req_sel),
    .sp_load(sp_load), .sp_load_val(sp_load_val), .sp(sp),
    .rf_sel(rf_sel), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .rf_wen_hi(rf_wen_hi), .rf_wen_lo(rf_wen_lo), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_push = 1'b0; req_sel = 3'd0;
    sp_load = 1'b0; sp_load_val = 16'h0000; mem_rdata = 8'h00; mem_ack = 1'b0;
    rf_hi[0] = 8'h12; rf_lo[0] = 8'h34;
    rf_hi[1] = 8'h56; rf_lo[1] = 8'h78;
    rf_hi[2] = 8'h9A; rf_lo[2] = 8'hBC;
    rf_hi[3] = 8'hA5; rf_lo[3] = 8'hB0;
    rf_hi[4] = 8'h01; rf_lo[4] = 8'h00;

    // Reset
    tick(); tick(); #2;
    chk("rst_sp", sp, 16'hFFFE);
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_ready", 16'(req_ready), 16'h1);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_rf_sel", 16'(rf_sel), 16'h0);
    chk("rst_addr", mem_addr, 16'h0000);
    rst_n = 1'b1;

    // PUSH BC, zero wait
    tick(); req_valid = 1; req_push = 1; req_sel = 3'd0; mem_ack = 1; #2;
    chk("pushbc_ready", 16'(req_ready), 16'h1);
    tick(); req_valid = 0; #2;
    chk("pushbc_c1_req", 16'(mem_req), 16'h1);
    chk("pushbc_c1_we", 16'(mem_we), 16'h1);
    chk("pushbc_c1_addr", mem_addr, 16'hFFFD);
    chk("pushbc_c1_wdata", 16'(mem_wdata), 16'h12);
    chk("pushbc_c1_done", 16'(done), 16'h0);
    tick(); #2;
    chk("pushbc_c2_addr", mem_addr, 16'hFFFC);
    chk("pushbc_c2_wdata", 16'(mem_wdata), 16'h34);
    tick(); #2;
    chk("pushbc_c3_done", 16'(done), 16'h1);
    chk("pushbc_c3_sp", sp, 16'hFFFC);
    chk("pushbc_c3_req", 16'(mem_req), 16'h0);
    tick(); #2;
    chk("pushbc_c4_done", 16'(done), 16'h0);
    chk("pushbc_c4_ready", 16'(req_ready), 16'h1);

    // POP AF, two wait cycles per access; sp_load while busy is ignored
    tick(); req_valid = 1; req_push = 0; req_sel = 3'd3; mem_ack = 0; #2;
    chk("popaf_ready", 16'(req_ready), 16'h1);
    tick(); req_valid = 0; sp_load = 1; sp_load_val = 16'h1234; #2;
    chk("popaf_c1_req", 16'(mem_req), 16'h1);
    chk("popaf_c1_we", 16'(mem_we), 16'h0);
    chk("popaf_c1_addr", mem_addr, 16'hFFFC);
    chk("popaf_c1_wen_lo", 16'(rf_wen_lo), 16'h0);
    chk("popaf_c1_ready", 16'(req_ready), 16'h0);
    chk("popaf_c1_rf_sel", 16'(rf_sel), 16'h3);
    tick(); sp_load = 0; #2;
    chk("popaf_c2_addr", mem_addr, 16'hFFFC);
    chk("popaf_c2_sp", sp, 16'hFFFC);
    tick(); mem_ack = 1; mem_rdata = 8'hBF; #2;
    chk("popaf_c3_wen_lo", 16'(rf_wen_lo), 16'h1);
    chk("popaf_c3_wdata", 16'(rf_wdata), 16'hB0);
    chk("popaf_c3_wen_hi", 16'(rf_wen_hi), 16'h0);
    tick(); mem_ack = 0; #2;
    chk("popaf_c4_addr", mem_addr, 16'hFFFD);
    chk("popaf_c4_wen_hi", 16'(rf_wen_hi), 16'h0);
    tick(); #2;
    chk("popaf_c5_req", 16'(mem_req), 16'h1);
    tick(); mem_ack = 1; mem_rdata = 8'hA5; #2;
    chk("popaf_c6_wen_hi", 16'(rf_wen_hi), 16'h1);
    chk("popaf_c6_wdata", 16'(rf_wdata), 16'hA5);
    chk("popaf_c6_wen_lo", 16'(rf_wen_lo), 16'h0);
    tick(); mem_ack = 0; #2;
    chk("popaf_c7_done", 16'(done), 16'h1);
    chk("popaf_c7_sp", sp, 16'hFFFE);
    tick(); #2;
    chk("popaf_c8_done", 16'(done), 16'h0);

    // Wrap-around through 0x0000
    tick(); sp_load = 1; sp_load_val = 16'h0001; #2;
    chk("wrap_load_ready", 16'(req_ready), 16'h0);
    tick(); sp_load = 0; req_valid = 1; req_push = 1; req_sel = 3'd1; mem_ack = 1; #2;
    chk("wrap_sp_loaded", sp, 16'h0001);
    chk("wrap_ready", 16'(req_ready), 16'h1);
    tick(); req_valid = 0; #2;
    chk("wrap_push_addr_hi", mem_addr, 16'h0000);
    chk("wrap_push_wdata_hi", 16'(mem_wdata), 16'h56);
    tick(); #2;
    chk("wrap_push_addr_lo", mem_addr, 16'hFFFF);
    chk("wrap_push_wdata_lo", 16'(mem_wdata), 16'h78);
    tick(); #2;
    chk("wrap_push_done", 16'(done), 16'h1);
    chk("wrap_push_sp", sp, 16'hFFFF);
    tick(); req_valid = 1; req_push = 0; req_sel = 3'd1; #2;
    chk("wrap_pop_ready", 16'(req_ready), 16'h1);
    tick(); req_valid = 0; mem_rdata = 8'h78; #2;
    chk("wrap_pop_addr_lo", mem_addr, 16'hFFFF);
    chk("wrap_pop_wdata_lo", 16'(rf_wdata), 16'h78);
    tick(); mem_rdata = 8'h56; #2;
    chk("wrap_pop_addr_hi", mem_addr, 16'h0000);
    chk("wrap_pop_wen_hi", 16'(rf_wen_hi), 16'h1);
    tick(); #2;
    chk("wrap_pop_done", 16'(done), 16'h1);
    chk("wrap_pop_sp", sp, 16'h0001);

    // sp_load and request together: load wins, request taken next cycle
    tick(); sp_load = 1; sp_load_val = 16'h8000; req_valid = 1; req_push = 1; req_sel = 3'd2; #2;
    chk("simul_ready_blocked", 16'(req_ready), 16'h0);
    tick(); sp_load = 0; #2;
    chk("simul_sp", sp, 16'h8000);
    chk("simul_ready", 16'(req_ready), 16'h1);
    tick(); req_valid = 0; #2;
    chk("simul_addr_hi", mem_addr, 16'h7FFF);
    chk("simul_wdata_hi", 16'(mem_wdata), 16'h9A);
    tick(); #2;
    chk("simul_addr_lo", mem_addr, 16'h7FFE);
    chk("simul_wdata_lo", 16'(mem_wdata), 16'hBC);
    tick(); #2;
    chk("simul_done", 16'(done), 16'h1);

    // Invalid select
    tick(); req_valid = 1; req_push = 0; req_sel = 3'd6; #2;
    chk("inv_ready", 16'(req_ready), 16'h1);
    tick(); req_valid = 0; #2;
    chk("inv_done", 16'(done), 16'h1);
    chk("inv_mem_req", 16'(mem_req), 16'h0);
    chk("inv_wen", 16'({rf_wen_hi, rf_wen_lo}), 16'h0);
    tick(); #2;
    chk("inv_done_clear", 16'(done), 16'h0);
    chk("inv_sp", sp, 16'h7FFE);

    // Reset during POP_HI wait
    tick(); req_valid = 1; req_push = 0; req_sel = 3'd0; mem_ack = 1; mem_rdata = 8'h11; #2;
    tick(); req_valid = 0; #2;
    chk("rstpop_wen_lo", 16'(rf_wen_lo), 16'h1);
    tick(); mem_ack = 0; rst_n = 0; #2;
    chk("rstpop_req_hi", 16'(mem_req), 16'h1);
    chk("rstpop_addr_hi", mem_addr, 16'h7FFF);
    tick(); rst_n = 1; mem_ack = 1; mem_rdata = 8'h22; #2;
    chk("rstpop_mem_req", 16'(mem_req), 16'h0);
    chk("rstpop_sp", sp, 16'hFFFE);
    chk("rstpop_wen_hi", 16'(rf_wen_hi), 16'h0);
    chk("rstpop_ready", 16'(req_ready), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sm83_stack_seq.md
# sm83_stack_seq

Stack-operation sequencer for the SM83 core. Owns the stack pointer and carries out PUSH/POP of a 16-bit register pair as two 8-bit memory cycles. It drives the register-file pair select and write enables and the CPU memory request port. It sits between the instruction decoder, which issues one request per PUSH/POP opcode, and the register file / bus interface.

## Interface
Parameters:
- SP_RESET, 16'hFFFE, stack pointer value after reset.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  decoder request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_push  in  1  1 = PUSH, 0 = POP; sampled at accept
- req_sel  in  3  pair select, stack_sel_t: BC=0, DE=1, HL=2, AF=3, PC=4; 5–7 invalid
- sp_load  in  1  load SP (LD SP,nn / LD SP,HL); honoured only in IDLE
- sp_load_val  in  16  value for sp_load
- sp  out  16  current stack pointer
- rf_sel  out  3  pair select to register file; holds latched req_sel while busy, 0 in IDLE
- rd_hi, rd_lo  in  8 each  combinational register-file read of the pair selected by rf_sel
- rf_wen_hi, rf_wen_lo  out  1 each  write strobes for the high and low byte of the rf_sel pair
- rf_wdata  out  8  write data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  16  byte address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid in the mem_ack cycle
- mem_ack  in  1  completes the current access; may be high in the first mem_req cycle
- done  out  1  one-cycle pulse when the operation finishes

## Operation
- States (stack_state_t): IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, DONE.
- IDLE:
  - req_ready = !sp_load.
  - sp_load has priority: it sets sp <= sp_load_val, and no request is accepted that cycle.
  - On accept, latch req_push and req_sel.
  - Next state: PUSH_HI if push, POP_LO if pop, DONE if req_sel ≥ 5 (no memory or register activity).
- PUSH_HI:
  - mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=rd_hi.
  - On ack: sp <= sp-1, go to PUSH_LO.
- PUSH_LO:
  - mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=rd_lo.
  - On ack: sp <= sp-1, go to DONE.
- POP_LO:
  - mem_req=1, mem_we=0, mem_addr=sp.
  - On ack: rf_wen_lo=1, rf_wdata=mem_rdata; when the pair is AF, rf_wdata = {mem_rdata[7:4],4'b0}.
  - On ack: sp <= sp+1, go to POP_HI.
- POP_HI:
  - mem_req=1, mem_we=0, mem_addr=sp.
  - On ack: rf_wen_hi=1, rf_wdata=mem_rdata, sp <= sp+1, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Without mem_ack, state, sp, and mem_addr/mem_we/mem_wdata hold; mem_req stays high and rf_wen_* stay 0.
- sp_load outside IDLE is ignored.
- SP arithmetic is modulo 2^16: 16'h0000-1 = 16'hFFFF and 16'hFFFF+1 = 16'h0000.
- Pair select PC: on POP, writes target the PC halves. Jump semantics (RET) belong to the decoder.

## Timing
- Reset values:
  - state IDLE, sp=SP_RESET.
  - req_ready=1 (if sp_load=0).
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rf_sel=0, rf_wen_hi=rf_wen_lo=0, rf_wdata=0, done=0.
- Outputs are decoded combinationally from registered state, registered sp and the listed inputs.
- rf_wen_* and rf_wdata depend combinationally on mem_ack and mem_rdata.
- Zero-wait PUSH or POP: accept in cycle 0, memory in cycles 1–2, done in cycle 3, req_ready in cycle 4. Total 4 cycles.
- Each wait cycle (mem_ack low) adds one cycle.
- Invalid select: accept in cycle 0, done in cycle 1.
- rst_n low in any state forces reset values on the next edge. Any in-flight access is abandoned with no register write. A POP interrupted after POP_LO leaves its low-byte write in place.

## Structure
- Add to sm83_pkg:
  - stack_sel_t (3-bit enum above)
  - stack_state_t
  - localparam F_LOW_MASK = 8'hF0
- Single module. SP increment/decrement is inline; no sub-module.

## Test plan
- Reset: sp=16'hFFFE, mem_req=0, req_ready=1, done=0.
- PUSH BC, BC=16'h1234, mem_ack tied high: writes 8'h12 @16'hFFFD, then 8'h34 @16'hFFFC. sp=16'hFFFC. done pulses in cycle 3.
- POP AF, memory [16'hFFFC]=8'hBF, [16'hFFFD]=8'hA5, two wait cycles per access: rf_wen_lo with 8'hB0, then rf_wen_hi with 8'hA5. sp=16'hFFFE. done in cycle 7.
- Wrap-around: sp_load 16'h0001, then PUSH DE: addresses 16'h0000 then 16'hFFFF, sp=16'hFFFF. Then POP DE returns sp=16'h0001.
- Simultaneous sp_load and req_valid in IDLE: sp takes the load value, req_ready=0 that cycle, and the request is accepted the next cycle using the new sp. Invalid req_sel=6: done in cycle 1 with no mem_req.
- rst_n low during POP_HI wait: next cycle mem_req=0, sp=16'hFFFE, no rf_wen_hi pulse.
